// File: rtl/ccd_frame_sequencer.sv
// Frame timing controller for a linear CCD: ICG/SH gate sequencing, per-pixel
// ADC strobes and a programmable integration period latched at each frame start.
module ccd_frame_sequencer #(
    parameter int ICG_LEAD = 2,
    parameter int SH_HIGH  = 25,
    parameter int ICG_LOW  = 100,
    parameter int NUM_PIX  = 3694,
    parameter int PIX_DIV  = 4,
    parameter int CNT_W    = 24,
    parameter int PIX_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic             icg,
    output logic             sh,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_idx,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic             clamped
);

    // state       | meaning
    // S_IDLE      | no frame in progress, gates parked (icg=1, sh=0)
    // S_ICG_LEAD  | icg low, waiting ICG_LEAD cycles before SH
    // S_SH_PULSE  | icg low, sh high for SH_HIGH cycles
    // S_ICG_TRAIL | icg low after SH until ICG_LOW cycles have elapsed
    // S_READOUT   | one pix_valid strobe every PIX_DIV cycles, NUM_PIX strobes
    // S_INTEG_WAIT| gates parked until the latched period expires

    localparam int               P_MIN_INT = ICG_LOW + NUM_PIX * PIX_DIV;
    localparam logic [CNT_W-1:0] P_MIN     = CNT_W'(P_MIN_INT);
    localparam int               TMR_W     = $clog2(ICG_LOW + PIX_DIV + 1);
    localparam logic [TMR_W-1:0] LEAD_LD   = TMR_W'(ICG_LEAD - 1);
    localparam logic [TMR_W-1:0] SH_LD     = TMR_W'(SH_HIGH - 1);
    localparam logic [TMR_W-1:0] TRAIL_LD  = TMR_W'(ICG_LOW - ICG_LEAD - SH_HIGH - 1);
    localparam logic [TMR_W-1:0] DIV_LD    = TMR_W'(PIX_DIV - 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ICG_LEAD,
        S_SH_PULSE,
        S_ICG_TRAIL,
        S_READOUT,
        S_INTEG_WAIT
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] prem;

    logic             clamp_req;
    logic [CNT_W-1:0] p_last;
    logic             frame_last;
    logic             start_frame;

    always_comb begin
        clamp_req   = (period < P_MIN);
        p_last      = (clamp_req ? P_MIN : period) - CNT_W'(1);
        frame_last  = (state != S_IDLE) && (prem == '0);
        start_frame = run && ((state == S_IDLE) || frame_last);
    end

    // prem is the frame's remaining-cycle down-counter; it alone decides the frame end,
    // so a period equal to P_MIN may end the frame while still in S_READOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tmr         <= '0;
            prem        <= '0;
            icg         <= 1'b1;
            sh          <= 1'b0;
            pix_valid   <= 1'b0;
            pix_idx     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            clamped     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pix_valid   <= 1'b0;
            if (start_frame) begin
                state       <= S_ICG_LEAD;
                tmr         <= LEAD_LD;
                prem        <= p_last;
                icg         <= 1'b0;
                sh          <= 1'b0;
                pix_idx     <= '0;
                frame_start <= 1'b1;
                frame_done  <= (p_last == '0);
                busy        <= 1'b1;
                clamped     <= clamp_req;
            end else if (frame_last) begin
                state   <= S_IDLE;
                tmr     <= '0;
                icg     <= 1'b1;
                sh      <= 1'b0;
                busy    <= 1'b0;
                clamped <= 1'b0;
            end else if (state != S_IDLE) begin
                prem       <= prem - CNT_W'(1);
                frame_done <= (prem == CNT_W'(1));
                case (state)
                    S_ICG_LEAD: begin
                        if (tmr != '0) begin
                            tmr <= tmr - TMR_W'(1);
                        end else begin
                            state <= S_SH_PULSE;
                            sh    <= 1'b1;
                            tmr   <= SH_LD;
                        end
                    end
                    S_SH_PULSE: begin
                        if (tmr != '0) begin
                            tmr <= tmr - TMR_W'(1);
                        end else begin
                            state <= S_ICG_TRAIL;
                            sh    <= 1'b0;
                            tmr   <= TRAIL_LD;
                        end
                    end
                    S_ICG_TRAIL: begin
                        if (tmr != '0) begin
                            tmr <= tmr - TMR_W'(1);
                        end else begin
                            state     <= S_READOUT;
                            icg       <= 1'b1;
                            pix_valid <= 1'b1;
                            pix_idx   <= '0;
                            tmr       <= DIV_LD;
                        end
                    end
                    S_READOUT: begin
                        if (tmr != '0) begin
                            tmr <= tmr - TMR_W'(1);
                        end else if (pix_idx == LAST_PIX) begin
                            state <= S_INTEG_WAIT;
                        end else begin
                            pix_valid <= 1'b1;
                            pix_idx   <= pix_idx + PIX_W'(1);
                            tmr       <= DIV_LD;
                        end
                    end
                    S_INTEG_WAIT: begin
                        tmr <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// Randomised and directed bench for ccd_frame_sequencer, checked every cycle against
// a frame-relative arithmetic model of the gate and strobe timing.
module tb_ccd_frame_sequencer;

    localparam int ICG_LEAD = 2;
    localparam int SH_HIGH  = 3;
    localparam int ICG_LOW  = 10;
    localparam int NUM_PIX  = 8;
    localparam int PIX_DIV  = 2;
    localparam int CNT_W    = 24;
    localparam int PIX_W    = 12;
    localparam int P_MIN    = ICG_LOW + NUM_PIX * PIX_DIV;

    logic             clk;
    logic             rst;
    logic             run;
    logic [CNT_W-1:0] period;
    logic             icg;
    logic             sh;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_idx;
    logic             frame_start;
    logic             frame_done;
    logic             busy;
    logic             clamped;

    int n_cmp = 0;
    int n_bad = 0;

    // model: active flag, frame-relative cycle, latched period, clamp flag, held pixel index
    bit m_act   = 1'b0;
    int m_t     = 0;
    int m_p     = P_MIN;
    bit m_clamp = 1'b0;
    int m_idx   = 0;

    ccd_frame_sequencer #(
        .ICG_LEAD(ICG_LEAD), .SH_HIGH(SH_HIGH), .ICG_LOW(ICG_LOW),
        .NUM_PIX(NUM_PIX), .PIX_DIV(PIX_DIV), .CNT_W(CNT_W), .PIX_W(PIX_W)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .period(period),
        .icg(icg), .sh(sh), .pix_valid(pix_valid), .pix_idx(pix_idx),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy), .clamped(clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        if (rst) begin
            m_act = 1'b0; m_t = 0; m_clamp = 1'b0; m_idx = 0;
        end else if (!m_act || m_t == m_p - 1) begin
            if (run) begin
                m_act   = 1'b1;
                m_t     = 0;
                m_clamp = (int'(period) < P_MIN);
                m_p     = m_clamp ? P_MIN : int'(period);
            end else begin
                m_act   = 1'b0;
                m_clamp = 1'b0;
            end
        end else begin
            m_t++;
        end
        if (m_act) begin
            if (m_t < ICG_LOW) m_idx = 0;
            else m_idx = ((m_t - ICG_LOW) / PIX_DIV > NUM_PIX - 1) ? NUM_PIX - 1 : (m_t - ICG_LOW) / PIX_DIV;
        end
    endtask

    function automatic logic [18:0] exp_v();
        logic e_icg, e_sh, e_pv, e_fs, e_fd, e_busy, e_cl;
        e_icg  = !(m_act && m_t < ICG_LOW);
        e_sh   = m_act && m_t >= ICG_LEAD && m_t < ICG_LEAD + SH_HIGH;
        e_pv   = m_act && m_t >= ICG_LOW && ((m_t - ICG_LOW) % PIX_DIV == 0)
                 && ((m_t - ICG_LOW) / PIX_DIV < NUM_PIX);
        e_fs   = m_act && m_t == 0;
        e_fd   = m_act && m_t == m_p - 1;
        e_busy = m_act;
        e_cl   = m_act && m_clamp;
        return {e_icg, e_sh, e_pv, e_fs, e_fd, e_busy, e_cl, PIX_W'(m_idx)};
    endfunction

    function automatic logic [18:0] obs_v();
        return {icg, sh, pix_valid, frame_start, frame_done, busy, clamped, pix_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; period = 24'd40;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
        n_cmp++;
        if (obs_v() !== 19'h40000) begin
            n_bad++;
            $display("FAIL reset_value: got %h want %h", obs_v(), 19'h40000);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int pv_cnt = 0;
        int fd_at  = -1;
        period = 24'd40; run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            run = 1'b0;
            if (pix_valid) pv_cnt++;
            if (frame_done) fd_at = i;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL single_frame cyc F+%0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
        n_cmp++;
        if (pv_cnt != NUM_PIX || fd_at != 39) begin
            n_bad++;
            $display("FAIL single_frame_totals: got strobes %0d done@%0d want %0d done@39", pv_cnt, fd_at, NUM_PIX);
        end
    endtask

    task automatic test_back_to_back();
        int fs_cnt = 0;
        period = 24'd40; run = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (frame_start) fs_cnt++;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL back_to_back cyc F+%0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
        n_cmp++;
        if (fs_cnt != 3) begin
            n_bad++;
            $display("FAIL back_to_back_starts: got %0d want 3", fs_cnt);
        end
        run = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL back_to_back_drain cyc %0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_clamp();
        period = 24'd5; run = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (i == 10) period = 24'd30;
            if (i == 30) run = 1'b0;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL clamp cyc F+%0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_period_change();
        period = 24'd40; run = 1'b1;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (i == 15) period = 24'd60;
            if (i == 45) run = 1'b0;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL period_change cyc F+%0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_reset_mid();
        period = 24'd40; run = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick();
            rst = (i == 12);
            if (i == 30) run = 1'b0;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL reset_mid cyc F+%0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_drop_run_sh();
        int fs_cnt = 0;
        period = 24'd40; run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 3) run = 1'b0;
            if (frame_start) fs_cnt++;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL drop_run_sh cyc F+%0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
        n_cmp++;
        if (fs_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_run_sh_single: got starts %0d busy %b want 1 0", fs_cnt, busy);
        end
    endtask

    task automatic test_boundary();
        int plist[4] = '{P_MIN - 1, P_MIN, P_MIN + 1, 0};
        foreach (plist[j]) begin
            period = CNT_W'(plist[j]); run = 1'b1;
            for (int i = 0; i < 35; i++) begin
                tick();
                run = 1'b0;
                n_cmp++;
                if (obs_v() !== exp_v()) begin
                    n_bad++;
                    $display("FAIL boundary p=%0d cyc %0d: got %h want %h", plist[j], i, obs_v(), exp_v());
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) period = CNT_W'($urandom_range(0, 60));
            if ($urandom_range(0, 9) == 0) run = ~run;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
        rst = 1'b0; run = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL random_drain cyc %0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; period = 24'd40;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_clamp();
        test_period_change();
        test_reset_mid();
        test_drop_run_sh();
        test_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
